// File: rtl/receiver.sv
// 8N1 UART receiver with half-bit-timed sampling and a byte holding store.
// Define RECEIVER_FIFO_EN to replace the holding register with a 4-entry FIFO.
module receiver #(
  parameter int CLK_PER_HALF_BIT = 1406
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  input  logic       rdata_pop,
  output logic       ferr,
  output logic       overrun,
  input  logic       err_clr
);

  localparam int CW = $clog2(2 * CLK_PER_HALF_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(2 * CLK_PER_HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [7:0]      sh;
  logic            rx_meta;
  logic            rxs;
  logic            half_tick;
  logic            full_tick;
  logic            push;
  logic            stop_bad;
  logic            pop;
  logic            full;
  logic            acc;
  logic            ovf;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  assign half_tick = (cnt == HALF_M1);
  assign full_tick = (cnt == FULL_M1);
  assign push      = (state == STOP) && full_tick && rxs;
  assign stop_bad  = (state == STOP) && full_tick && !rxs;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (half_tick) begin
            if (rxs) begin
              state <= IDLE;
            end else begin
              state <= DATA;
              idx   <= '0;
              cnt   <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (full_tick) begin
            sh[idx] <= rxs;
            cnt     <= '0;
            if (idx == 3'd7) state <= STOP;
            else idx <= idx + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (full_tick) begin
            cnt   <= '0;
            state <= rxs ? IDLE : WAIT_HIGH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          // a low line here is the tail of a broken frame, not a start
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pop = rdata_pop && rdata_valid;
  assign acc = push && (!full || pop);
  assign ovf = push && full && !pop;

`ifdef RECEIVER_FIFO_EN
  logic [7:0] mem [4];
  logic [1:0] wp;
  logic [1:0] rp;
  logic [2:0] count;

  assign full        = (count == 3'd4);
  assign rdata       = mem[rp];
  assign rdata_valid = (count != 3'd0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      if (acc) begin
        mem[wp] <= sh;
        wp      <= wp + 2'd1;
      end
      if (pop) rp <= rp + 2'd1;
      count <= count + {2'b00, acc} - {2'b00, pop};
    end
  end
`else
  logic [7:0] hold;
  logic       hvalid;

  assign full        = hvalid;
  assign rdata       = hold;
  assign rdata_valid = hvalid;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      hold   <= '0;
      hvalid <= 1'b0;
    end else if (acc) begin
      hold   <= sh;
      hvalid <= 1'b1;
    end else if (pop) begin
      hvalid <= 1'b0;
    end
  end
`endif

  // a set in the same cycle as err_clr takes priority
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ferr    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      ferr    <= stop_bad || (ferr && !err_clr);
      overrun <= ovf || (overrun && !err_clr);
    end
  end

endmodule

// File: tb/tb_receiver.sv
// Directed bench for receiver at CLK_PER_HALF_BIT=4 (8 clocks per bit).
// Works in both the holding-register and RECEIVER_FIFO_EN builds.
module tb_receiver;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic       rdata_pop = 1'b0;
  logic       ferr;
  logic       overrun;
  logic       err_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  receiver #(.CLK_PER_HALF_BIT(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rxd        (rxd),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .rdata_pop  (rdata_pop),
    .ferr       (ferr),
    .overrun    (overrun),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_out(input logic v);
    rxd = v;
    tick(8);
  endtask

  // start + 8 data bits; returns with the stop level just driven
  task automatic send(input logic [7:0] d, input logic stp);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    rxd = stp;
  endtask

  task automatic frame_ok(input logic [7:0] d);
    send(d, 1'b1);
    tick(8);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk(tag, {7'd0, rdata_valid}, 16'd1);
    chk(tag, {8'd0, rdata}, {8'd0, exp});
    rdata_pop = 1'b1;
    tick(1);
    rdata_pop = 1'b0;
  endtask

  task automatic clr_pulse();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  initial begin
    tick(3);
    chk("rst_rdata", {8'd0, rdata}, 16'h0000);
    chk("rst_valid", {15'd0, rdata_valid}, 16'd0);
    chk("rst_ferr", {15'd0, ferr}, 16'd0);
    chk("rst_ovr", {15'd0, overrun}, 16'd0);
    rstn = 1'b1;
    tick(4);

    // push lands exactly one cycle after the stop sample
    send(8'hA5, 1'b1);
    tick(6);
    chk("a5_early", {15'd0, rdata_valid}, 16'd0);
    tick(1);
    chk("a5_valid", {15'd0, rdata_valid}, 16'd1);
    chk("a5_data", {8'd0, rdata}, 16'h00A5);
    tick(1);
    chk("a5_ferr", {15'd0, ferr}, 16'd0);
    chk("a5_ovr", {15'd0, overrun}, 16'd0);
    pop_chk("a5_pop", 8'hA5);
    chk("a5_empty", {15'd0, rdata_valid}, 16'd0);

    // glitch shorter than half a bit
    rxd = 1'b0;
    tick(3);
    rxd = 1'b1;
    tick(20);
    chk("glitch_valid", {15'd0, rdata_valid}, 16'd0);
    chk("glitch_ferr", {15'd0, ferr}, 16'd0);
    frame_ok(8'h3C);
    pop_chk("3c", 8'h3C);

    // framing error, line stuck low past the stop bit
    send(8'h55, 1'b0);
    tick(28);
    chk("fe_ferr", {15'd0, ferr}, 16'd1);
    chk("fe_valid", {15'd0, rdata_valid}, 16'd0);
    rxd = 1'b1;
    tick(10);
    frame_ok(8'h0F);
    chk("fe_keep", {15'd0, ferr}, 16'd1);
    pop_chk("0f", 8'h0F);
    clr_pulse();
    chk("fe_clr", {15'd0, ferr}, 16'd0);

`ifdef RECEIVER_FIFO_EN
    for (int i = 1; i <= 5; i++) frame_ok(8'(i));
    chk("ovr_set", {15'd0, overrun}, 16'd1);
    for (int i = 1; i <= 4; i++) pop_chk("ovr_pop", 8'(i));
    chk("ovr_empty", {15'd0, rdata_valid}, 16'd0);
`else
    frame_ok(8'h11);
    frame_ok(8'h22);
    chk("ovr_set", {15'd0, overrun}, 16'd1);
    pop_chk("ovr_head", 8'h11);
    chk("ovr_empty", {15'd0, rdata_valid}, 16'd0);
`endif
    clr_pulse();
    chk("ovr_clr", {15'd0, overrun}, 16'd0);

    // full store, pop on the same edge as the next push
`ifdef RECEIVER_FIFO_EN
    frame_ok(8'h10);
    frame_ok(8'h20);
    frame_ok(8'h30);
    frame_ok(8'h40);
    send(8'h50, 1'b1);
    tick(6);
    rdata_pop = 1'b1;
    tick(1);
    rdata_pop = 1'b0;
    tick(1);
    chk("fp_ovr", {15'd0, overrun}, 16'd0);
    pop_chk("fp_20", 8'h20);
    pop_chk("fp_30", 8'h30);
    pop_chk("fp_40", 8'h40);
    pop_chk("fp_50", 8'h50);
    chk("fp_empty", {15'd0, rdata_valid}, 16'd0);
`else
    frame_ok(8'hAA);
    send(8'hBB, 1'b1);
    tick(6);
    rdata_pop = 1'b1;
    tick(1);
    rdata_pop = 1'b0;
    tick(1);
    chk("fp_ovr", {15'd0, overrun}, 16'd0);
    pop_chk("fp_bb", 8'hBB);
    chk("fp_empty", {15'd0, rdata_valid}, 16'd0);
`endif

    // reset during data bit 4 of 8'hFF
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(1'b1);
    rxd = 1'b1;
    tick(3);
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick(40);
    chk("mr_valid", {15'd0, rdata_valid}, 16'd0);
    chk("mr_ferr", {15'd0, ferr}, 16'd0);
    chk("mr_ovr", {15'd0, overrun}, 16'd0);
    frame_ok(8'h81);
    pop_chk("mr_81", 8'h81);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
